// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding selects, stall/flush generation and
// a multiply/divide freeze sequencer for the five-stage core.
module hazard_unit #(
  parameter int REGW      = 5,
  parameter int MD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic            branchD,
  input  logic            pcsrcD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic            multdivE,
  input  logic [REGW-1:0] writeregM,
  input  logic            regwriteM,
  input  logic            memtoregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteW,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            mdbusy
);

  localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lwstall, branchstall, mdstall, stall;

  // Register 0 is hardwired, so it never matches a producer.
  function automatic logic hit(
    input logic [REGW-1:0] a,
    input logic [REGW-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdbusy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        mdbusy = multdivE;
        if (multdivE) begin
          cnt_d   = CW'(MD_CYCLES - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        mdbusy = 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    forwardAE = 2'b00;
    if (regwriteM && hit(rsE, writeregM))      forwardAE = 2'b10;
    else if (regwriteW && hit(rsE, writeregW)) forwardAE = 2'b01;
    forwardBE = 2'b00;
    if (regwriteM && hit(rtE, writeregM))      forwardBE = 2'b10;
    else if (regwriteW && hit(rtE, writeregW)) forwardBE = 2'b01;
  end

  assign forwardAD = regwriteM && hit(rsD, writeregM);
  assign forwardBD = regwriteM && hit(rtD, writeregM);

  assign lwstall = memtoregE &&
                   (hit(rsD, writeregE) || hit(rtD, writeregE));
  assign branchstall = branchD && (
    (regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
    (memtoregM && (hit(rsD, writeregM) || hit(rtD, writeregM))));

  assign mdstall = mdbusy;
  assign stall   = lwstall | branchstall | mdstall;

  // Execute only takes a bubble when it is not itself frozen.
  assign stallF = stall;
  assign stallD = stall;
  assign stallE = mdstall;
  assign flushE = (lwstall | branchstall) & ~mdstall;
  assign flushM = mdstall;
  assign flushD = pcsrcD & ~stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vectors, freeze/reset
// sequences and random stimulus against a behavioural model.
module tb_hazard_unit;

  localparam int MD = 4;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, weE, weM, weW;
    logic       brD, pcD, rwE, mtE, mdE, rwM, mtM, rwW;
  } in_t;

  typedef struct {
    in_t         in;
    logic [12:0] exp;
    string       nm;
  } vec_t;

  logic       clk = 0, reset = 1;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, pcsrcD, regwriteE, memtoregE, multdivE;
  logic       regwriteM, memtoregM, regwriteW;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, stallE;
  logic       flushD, flushE, flushM, mdbusy;

  int total = 0, bad = 0;
  int left = 0;
  bit done_c = 0;

  hazard_unit #(.REGW(5), .MD_CYCLES(MD)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .pcsrcD(pcsrcD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE),
    .multdivE(multdivE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .mdbusy(mdbusy)
  );

  always #5 clk = ~clk;

  task automatic drive(input in_t v);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeregE = v.weE; writeregM = v.weM; writeregW = v.weW;
    branchD = v.brD; pcsrcD = v.pcD; regwriteE = v.rwE;
    memtoregE = v.mtE; multdivE = v.mdE; regwriteM = v.rwM;
    memtoregM = v.mtM; regwriteW = v.rwW;
  endtask

  function automatic logic [12:0] got();
    return {forwardAE, forwardBE, forwardAD, forwardBD, stallF,
            stallD, stallE, flushD, flushE, flushM, mdbusy};
  endfunction

  function automatic bit m(input logic [4:0] a, input logic [4:0] b);
    return a != 0 && a == b;
  endfunction

  // Reference: rules evaluated directly; freeze tracked as cycles left.
  function automatic logic [12:0] model(input in_t v);
    logic [1:0] a, b;
    bit lw, br, md, st;
    md = (left > 0) ? 1'b1 : (done_c ? 1'b0 : v.mdE);
    a = (v.rwM && m(v.rsE, v.weM)) ? 2 : (v.rwW && m(v.rsE, v.weW)) ? 1 : 0;
    b = (v.rwM && m(v.rtE, v.weM)) ? 2 : (v.rwW && m(v.rtE, v.weW)) ? 1 : 0;
    lw = v.mtE && (m(v.rsD, v.weE) || m(v.rtD, v.weE));
    br = v.brD && ((v.rwE && (m(v.rsD, v.weE) || m(v.rtD, v.weE))) ||
                   (v.mtM && (m(v.rsD, v.weM) || m(v.rtD, v.weM))));
    st = lw | br | md;
    return {a, b, v.rwM && m(v.rsD, v.weM), v.rwM && m(v.rtD, v.weM),
            st, st, md, v.pcD & ~st, (lw | br) & ~md, md, md};
  endfunction

  task automatic advance(input in_t v);
    if (left > 0) begin
      left--;
      if (left == 0) done_c = 1;
    end else if (done_c) done_c = 0;
    else if (v.mdE) left = MD - 1;
  endtask

  task automatic check(input string nm, input logic [12:0] e);
    total++;
    if (got() !== e) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, got(), e);
    end
  endtask

  task automatic cyc(input in_t v, input logic [12:0] e,
                     input string nm, input bit use_e);
    logic [12:0] want;
    drive(v);
    #2;
    want = use_e ? e : model(v);
    check(nm, want);
    @(posedge clk);
    advance(v);
    #1;
  endtask

  localparam logic [12:0] LOADUSE = 13'b0000_00_11_0_0_1_0_0;
  localparam logic [12:0] FREEZE  = 13'b0000_00_11_1_0_0_1_1;

  vec_t tbl[12];
  in_t  z, v;

  initial begin
    z = '0;
    drive(z);
    #2;
    check("reset_state", 13'b0);
    @(posedge clk);
    #1 reset = 0;

    for (int i = 0; i < 12; i++) begin
      tbl[i].in = z;
      tbl[i].exp = 13'b0;
    end
    tbl[0].nm = "all_zero";
    tbl[1].nm = "fwd_mem_prio";
    tbl[1].in.rsE = 3; tbl[1].in.rtE = 3;
    tbl[1].in.weM = 3; tbl[1].in.rwM = 1;
    tbl[1].in.weW = 3; tbl[1].in.rwW = 1;
    tbl[1].exp = 13'b1010_000000000;
    tbl[2] = tbl[1]; tbl[2].nm = "fwd_wb";
    tbl[2].in.rwM = 0; tbl[2].exp = 13'b0101_000000000;
    tbl[3] = tbl[2]; tbl[3].nm = "fwd_r0";
    tbl[3].in.rsE = 0; tbl[3].exp = 13'b0001_000000000;
    tbl[4].nm = "load_use";
    tbl[4].in.mtE = 1; tbl[4].in.weE = 5; tbl[4].in.rtD = 5;
    tbl[4].exp = LOADUSE;
    tbl[5].nm = "branch_ex";
    tbl[5].in.brD = 1; tbl[5].in.rsD = 7;
    tbl[5].in.rwE = 1; tbl[5].in.weE = 7;
    tbl[5].exp = LOADUSE;
    tbl[6].nm = "branch_memload";
    tbl[6].in.brD = 1; tbl[6].in.rsD = 7;
    tbl[6].in.mtM = 1; tbl[6].in.weM = 7;
    tbl[6].exp = LOADUSE;
    tbl[7].nm = "branch_fwdAD";
    tbl[7].in.brD = 1; tbl[7].in.rsD = 7;
    tbl[7].in.rwM = 1; tbl[7].in.weM = 7;
    tbl[7].exp = 13'b0000_1_0_0000000;
    tbl[8].nm = "taken_flushD";
    tbl[8].in.pcD = 1; tbl[8].exp = 13'b0000_00_00_1_0_0_0_0 >> 0;
    tbl[8].exp = 13'b0000_0_0_0_0_0_1_0_0_0;
    tbl[9].nm = "taken_lwstall";
    tbl[9].in.pcD = 1; tbl[9].in.mtE = 1;
    tbl[9].in.weE = 5; tbl[9].in.rsD = 5;
    tbl[9].exp = LOADUSE;
    tbl[10].nm = "r0_no_match";
    tbl[10].in.mtE = 1; tbl[10].in.rwM = 1; tbl[10].in.rwW = 1;
    tbl[10].in.rwE = 1; tbl[10].in.brD = 1;
    tbl[11].nm = "fwdBD";
    tbl[11].in.rtD = 9; tbl[11].in.weM = 9; tbl[11].in.rwM = 1;
    tbl[11].exp = 13'b0000_0_1_0000000;

    for (int i = 0; i < 12; i++)
      cyc(tbl[i].in, tbl[i].exp, tbl[i].nm, 1);

    // Held multiply/divide: 4 frozen, DONE, then a second freeze.
    v = z; v.mdE = 1;
    for (int i = 0; i < MD; i++) cyc(v, FREEZE, "md_freeze", 1);
    cyc(v, 13'b0, "md_done", 1);
    for (int i = 0; i < MD; i++) cyc(v, FREEZE, "md_freeze2", 1);
    v.mdE = 0;
    cyc(v, 13'b0, "md_done2", 1);
    cyc(v, 13'b0, "md_idle", 1);

    // Load-use during a freeze: no bubble in Execute.
    v = z; v.mdE = 1; v.mtE = 1; v.weE = 5; v.rtD = 5;
    cyc(v, FREEZE, "md_lw_first", 1);
    v.mdE = 0;
    for (int i = 1; i < MD; i++) cyc(v, FREEZE, "md_lw", 1);
    cyc(v, LOADUSE, "lw_after_md", 1);

    // Asynchronous reset in the second freeze cycle.
    v = z; v.mdE = 1;
    cyc(v, FREEZE, "rst_pre", 1);
    drive(v);
    #2 check("rst_run", FREEZE);
    v.mdE = 0;
    drive(v);
    reset = 1;
    #1 check("rst_async", 13'b0);
    left = 0; done_c = 0;
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 3; i++) cyc(z, 13'b0, "rst_idle", 1);

    for (int i = 0; i < 400; i++) begin
      v = z;
      v.rsD = 5'($urandom_range(0, 3)); v.rtD = 5'($urandom_range(0, 3));
      v.rsE = 5'($urandom_range(0, 3)); v.rtE = 5'($urandom_range(0, 3));
      v.weE = 5'($urandom_range(0, 3)); v.weM = 5'($urandom_range(0, 3));
      v.weW = 5'($urandom_range(0, 3));
      v.brD = 1'($urandom); v.pcD = 1'($urandom);
      v.rwE = 1'($urandom); v.mtE = 1'($urandom);
      v.rwM = 1'($urandom); v.mtM = 1'($urandom);
      v.rwW = 1'($urandom);
      v.mdE = ($urandom_range(0, 7) == 0);
      cyc(v, 13'b0, "random", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the five-stage processor. It drives the enable (stall) and reset/clear (flush) inputs of the inter-stage pipeline registers, and the operand-forwarding mux selects in the Decode and Execute stages. It contains a small state machine that holds the pipeline while a multi-cycle multiply/divide sits in Execute. All outputs are combinational from the current inputs and the internal state.

## Interface
- REGW, 5, register-address width
- MD_CYCLES, 4, stall cycles per multiply/divide; minimum 2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears the state machine immediately
- rsD, rtD  in  REGW  source registers of the instruction in Decode
- branchD  in  1  Decode holds a branch needing register operands
- pcsrcD  in  1  branch taken, resolved in Decode
- rsE, rtE  in  REGW  source registers of the instruction in Execute
- writeregE  in  REGW  destination register in Execute
- regwriteE, memtoregE  in  1  Execute writes a register / is a load
- multdivE  in  1  Execute holds a multi-cycle multiply/divide
- writeregM  in  REGW  destination register in Memory
- regwriteM, memtoregM  in  1  Memory writes a register / is a load
- writeregW  in  REGW  destination register in Writeback
- regwriteW  in  1  Writeback writes a register
- forwardAE, forwardBE  out  2  Execute operand select: 00 register file, 01 Writeback result, 10 Memory ALU result
- forwardAD, forwardBD  out  1  Decode comparator operand from Memory ALU result
- stallF, stallD, stallE  out  1  deassert the enable of the PC / IF-ID / ID-EX registers
- flushD, flushE, flushM  out  1  clear the IF-ID / ID-EX / EX-MEM registers
- mdbusy  out  1  equals the multiply/divide stall term

## Operation
- Register 0 never matches. Every match term below also requires that the register number be nonzero.
- forwardAE:
  - 10 if rsE==writeregM and regwriteM.
  - Otherwise 01 if rsE==writeregW and regwriteW.
  - Otherwise 00.
  - Memory takes priority over Writeback.
- forwardBE: same rules as forwardAE, using rtE.
- forwardAD = rsD==writeregM and regwriteM. forwardBD: same with rtD.
- lwstall = memtoregE and (writeregE==rsD or writeregE==rtD).
- branchstall = branchD and ((regwriteE and writeregE∈{rsD,rtD}) or (memtoregM and writeregM∈{rsD,rtD})).
- mdstall = mdbusy, as defined by the state machine below.
- stallF = stallD = lwstall | branchstall | mdstall.
- flushE = (lwstall | branchstall) & ~mdstall. This inserts a bubble into Execute only when Execute itself is not frozen.
- stallE = mdstall. flushM = mdstall, so a bubble enters Memory for every frozen cycle.
- flushD = pcsrcD & ~stallD.
- State machine: states IDLE, RUN, DONE, plus a counter cnt of width clog2(MD_CYCLES).
  - IDLE: mdstall = multdivE. If multdivE, load cnt <= MD_CYCLES-1 and go to RUN; otherwise stay in IDLE.
  - RUN: mdstall = 1. Decrement cnt. When cnt==1, go to DONE.
  - DONE: mdstall = 0. The multiply/divide instruction leaves Execute at this edge. Always go to IDLE. multdivE is ignored in DONE, so the same instruction does not restart.
- Back-to-back multiply/divide instructions: the second one enters Execute after DONE and is seen in IDLE, which starts a new sequence.

## Timing
- Reset state: IDLE, cnt=0. With all inputs 0, every output is 0, including forwardAE = forwardBE = 00.
- Reset asserted mid-RUN returns the machine to IDLE asynchronously. mdstall drops in the same cycle.
- Each multiply/divide freezes F, D and E for exactly MD_CYCLES cycles, starting with the cycle in which multdivE first rises.
- lwstall and branchstall add no latency of their own: one stall cycle per occurrence, driven by the pipeline.
- Simultaneous lwstall and mdstall: stalls are asserted and flushE=0. The load-use check re-evaluates after the freeze ends.
- pcsrcD while stallD=1: flushD=0. The branch re-resolves after the stall.

## Test plan
- Forwarding priority: rsE=rtE=3; writeregM=3, regwriteM=1; writeregW=3, regwriteW=1 -> forwardAE=forwardBE=10. Then drop regwriteM -> 01. Then set rsE=0 -> forwardAE=00.
- Load-use: memtoregE=1, writeregE=5, rtD=5 -> stallF=stallD=flushE=1, stallE=0, flushM=0. The following cycle with memtoregE=0 -> all 0.
- Branch hazard: branchD=1, rsD=7, regwriteE=1, writeregE=7 -> stall plus flushE. Next cycle memtoregM=1, writeregM=7 -> stall again. Next cycle with regwriteM=1 only -> forwardAD=1, no stall.
- Multiply/divide with MD_CYCLES=4: multdivE held high -> mdstall=stallE=flushM=1 for exactly 4 cycles, then 0 in DONE, then IDLE. With multdivE still high in the next IDLE cycle, a second 4-cycle freeze starts.
- Reset asserted during cycle 2 of a RUN -> mdbusy=0 immediately, with no clock edge. After release with multdivE=0 -> stays IDLE.
- Taken branch: pcsrcD=1, no hazards -> flushD=1. Repeat with lwstall active -> flushD=0.
